// File: rtl/hynoc_egress_fifo.sv
// rtl/hynoc_egress_fifo.sv - HyNoC router egress FIFO with packet count and sticky flags
// Optional HYNOC_EGRESS_STATS_EN adds stat_flits_out / stat_packets_out read counters.
module hynoc_egress_fifo #(
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1
) (
  input  logic                       local_clk,
  input  logic                       local_arstn,
  input  logic                       router_egress_write,
  input  logic [FLIT_WIDTH-1:0]      router_egress_data,
  output logic                       router_egress_full,
  input  logic                       local_egress_read,
  output logic [FLIT_WIDTH-1:0]      local_egress_data,
  output logic [LOG2_FIFO_DEPTH:0]   local_egress_fifo_level,
  output logic [LOG2_FIFO_DEPTH:0]   local_egress_packet_count,
  output logic                       overflow,
  output logic                       underflow
`ifdef HYNOC_EGRESS_STATS_EN
  ,
  output logic [31:0]                stat_flits_out,
  output logic [31:0]                stat_packets_out
`endif
);

  localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam logic [LOG2_FIFO_DEPTH:0] LEVEL_FULL = {1'b1, {LOG2_FIFO_DEPTH{1'b0}}};

  logic [FLIT_WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr;
  logic [LOG2_FIFO_DEPTH-1:0] rd_ptr;
  logic [LOG2_FIFO_DEPTH:0]   level_next;
  logic                       fifo_empty;
  logic                       wr_acc;
  logic                       rd_acc;
  logic                       pkt_in;
  logic                       pkt_out;

  // Accept decisions use only registered state, so no write-to-read or read-to-full comb path exists.
  assign fifo_empty = (local_egress_fifo_level == '0);
  assign wr_acc     = router_egress_write & ~router_egress_full;
  assign rd_acc     = local_egress_read & ~fifo_empty;
  assign pkt_in     = wr_acc & router_egress_data[PAYLOAD_WIDTH];
  assign pkt_out    = rd_acc & mem[rd_ptr][PAYLOAD_WIDTH];

  always_comb begin
    level_next = local_egress_fifo_level;
    case ({wr_acc, rd_acc})
      2'b10:   level_next = local_egress_fifo_level + 1'b1;
      2'b01:   level_next = local_egress_fifo_level - 1'b1;
      default: level_next = local_egress_fifo_level;
    endcase
  end

  // Storage is not reset; emptiness is tracked purely by the pointers and level.
  always_ff @(posedge local_clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= router_egress_data;
    end
  end

  always_ff @(posedge local_clk or negedge local_arstn) begin
    if (!local_arstn) begin
      wr_ptr                    <= '0;
      rd_ptr                    <= '0;
      local_egress_fifo_level   <= '0;
      local_egress_packet_count <= '0;
      local_egress_data         <= '0;
      router_egress_full        <= 1'b0;
      overflow                  <= 1'b0;
      underflow                 <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr            <= rd_ptr + 1'b1;
        local_egress_data <= mem[rd_ptr];
      end
      local_egress_fifo_level <= level_next;
      router_egress_full      <= (level_next == LEVEL_FULL);
      case ({pkt_in, pkt_out})
        2'b10:   local_egress_packet_count <= local_egress_packet_count + 1'b1;
        2'b01:   local_egress_packet_count <= local_egress_packet_count - 1'b1;
        default: local_egress_packet_count <= local_egress_packet_count;
      endcase
      if (router_egress_write & router_egress_full) begin
        overflow <= 1'b1;
      end
      if (local_egress_read & fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef HYNOC_EGRESS_STATS_EN
  always_ff @(posedge local_clk or negedge local_arstn) begin
    if (!local_arstn) begin
      stat_flits_out   <= '0;
      stat_packets_out <= '0;
    end else begin
      if (rd_acc) begin
        stat_flits_out <= stat_flits_out + 32'd1;
      end
      if (pkt_out) begin
        stat_packets_out <= stat_packets_out + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hynoc_egress_fifo.sv
// tb/tb_hynoc_egress_fifo.sv - directed table-driven bench for hynoc_egress_fifo (depth 4)
module tb_hynoc_egress_fifo;

  localparam int LOG2 = 2;
  localparam int PW   = 32;
  localparam int FW   = PW + 1;

  logic          local_clk;
  logic          local_arstn;
  logic          router_egress_write;
  logic [FW-1:0] router_egress_data;
  logic          router_egress_full;
  logic          local_egress_read;
  logic [FW-1:0] local_egress_data;
  logic [LOG2:0] local_egress_fifo_level;
  logic [LOG2:0] local_egress_packet_count;
  logic          overflow;
  logic          underflow;
`ifdef HYNOC_EGRESS_STATS_EN
  logic [31:0]   stat_flits_out;
  logic [31:0]   stat_packets_out;
`endif

  hynoc_egress_fifo #(
    .LOG2_FIFO_DEPTH(LOG2),
    .PAYLOAD_WIDTH(PW),
    .FLIT_WIDTH(FW)
  ) dut (
    .local_clk(local_clk),
    .local_arstn(local_arstn),
    .router_egress_write(router_egress_write),
    .router_egress_data(router_egress_data),
    .router_egress_full(router_egress_full),
    .local_egress_read(local_egress_read),
    .local_egress_data(local_egress_data),
    .local_egress_fifo_level(local_egress_fifo_level),
    .local_egress_packet_count(local_egress_packet_count),
    .overflow(overflow),
    .underflow(underflow)
`ifdef HYNOC_EGRESS_STATS_EN
    ,
    .stat_flits_out(stat_flits_out),
    .stat_packets_out(stat_packets_out)
`endif
  );

  initial begin
    local_clk = 1'b0;
    forever #5 local_clk = ~local_clk;
  end

  typedef struct {
    logic          wr;
    logic [FW-1:0] wd;
    logic          rd;
    logic [FW-1:0] data;
    logic [LOG2:0] level;
    logic          full;
    logic [LOG2:0] pc;
    logic          ovf;
    logic          unf;
  } vec_t;

  int n_cmp;
  int n_fail;
  vec_t vecs[16];

  function automatic vec_t mk(logic wr, logic [FW-1:0] wd, logic rd, logic [FW-1:0] data,
                              logic [LOG2:0] level, logic full, logic [LOG2:0] pc,
                              logic ovf, logic unf);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.data = data; v.level = level;
    v.full = full; v.pc = pc; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  function automatic logic [FW-1:0] flit(int k);
    logic [FW-1:0] f;
    f = (k == 50) ? 33'h1_0000ABCD : FW'(k);
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [FW-1:0] data, input logic [LOG2:0] level,
                           input logic full, input logic [LOG2:0] pc, input logic ovf, input logic unf);
    check({tag, ".data"},  64'(local_egress_data), 64'(data));
    check({tag, ".level"}, 64'(local_egress_fifo_level), 64'(level));
    check({tag, ".full"},  64'(router_egress_full), 64'(full));
    check({tag, ".pc"},    64'(local_egress_packet_count), 64'(pc));
    check({tag, ".ovf"},   64'(overflow), 64'(ovf));
    check({tag, ".unf"},   64'(underflow), 64'(unf));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //       wr  wdata           rd  exp data        lvl full pc ovf unf
    vecs[0]  = mk(1, 33'h0_00000001, 0, 33'h0,          1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 33'h0_00000002, 0, 33'h0,          2, 0, 0, 0, 0);
    vecs[2]  = mk(1, 33'h0_00000003, 0, 33'h0,          3, 0, 0, 0, 0);
    vecs[3]  = mk(0, 33'h0,          1, 33'h0_00000001, 2, 0, 0, 0, 0);
    vecs[4]  = mk(0, 33'h0,          1, 33'h0_00000002, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 33'h0,          1, 33'h0_00000003, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 33'h1_00000010, 1, 33'h0_00000003, 1, 0, 1, 0, 1);
    vecs[7]  = mk(1, 33'h0_00000011, 0, 33'h0_00000003, 2, 0, 1, 0, 1);
    vecs[8]  = mk(1, 33'h1_00000012, 0, 33'h0_00000003, 3, 0, 2, 0, 1);
    vecs[9]  = mk(1, 33'h0_00000013, 0, 33'h0_00000003, 4, 1, 2, 0, 1);
    vecs[10] = mk(1, 33'h0_00000014, 0, 33'h0_00000003, 4, 1, 2, 1, 1);
    vecs[11] = mk(1, 33'h0_00000015, 1, 33'h1_00000010, 3, 0, 1, 1, 1);
    vecs[12] = mk(0, 33'h0,          1, 33'h0_00000011, 2, 0, 1, 1, 1);
    vecs[13] = mk(0, 33'h0,          1, 33'h1_00000012, 1, 0, 0, 1, 1);
    vecs[14] = mk(0, 33'h0,          1, 33'h0_00000013, 0, 0, 0, 1, 1);
    vecs[15] = mk(0, 33'h0,          1, 33'h0_00000013, 0, 0, 0, 1, 1);

    local_arstn         = 1'b0;
    router_egress_write = 1'b0;
    router_egress_data  = '0;
    local_egress_read   = 1'b0;
    tick();
    tick();
    check_all("reset", '0, '0, 1'b0, '0, 1'b0, 1'b0);
    local_arstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      router_egress_write = vecs[i].wr;
      router_egress_data  = vecs[i].wd;
      local_egress_read   = vecs[i].rd;
      tick();
      check_all($sformatf("v%0d", i), vecs[i].data, vecs[i].level, vecs[i].full,
                vecs[i].pc, vecs[i].ovf, vecs[i].unf);
    end
    router_egress_write = 1'b0;
    local_egress_read   = 1'b0;

    // 100-flit stream with write and read held high, wrapping the pointers many times
    local_arstn = 1'b0;
    tick();
    local_arstn = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      router_egress_write = (k <= 100);
      router_egress_data  = (k <= 100) ? flit(k) : '0;
      local_egress_read   = 1'b1;
      tick();
      if (k >= 2) check($sformatf("stream%0d.data", k), 64'(local_egress_data), 64'(flit(k - 1)));
      check($sformatf("stream%0d.pc", k), 64'(local_egress_packet_count), (k == 50) ? 64'd1 : 64'd0);
      check($sformatf("stream%0d.level", k), 64'(local_egress_fifo_level), (k <= 100) ? 64'd1 : 64'd0);
    end
    router_egress_write = 1'b0;
    local_egress_read   = 1'b0;
    check("stream.unf", 64'(underflow), 64'd1);
    check("stream.ovf", 64'(overflow), 64'd0);
`ifdef HYNOC_EGRESS_STATS_EN
    check("stat_flits", 64'(stat_flits_out), 64'd100);
    check("stat_packets", 64'(stat_packets_out), 64'd1);
`endif

    // asynchronous reset with two flits held
    router_egress_write = 1'b1;
    router_egress_data  = 33'h0_0000000A;
    tick();
    router_egress_data  = 33'h1_0000000B;
    tick();
    router_egress_data  = 33'h0_0000000C;
    tick();
    router_egress_write = 1'b0;
    local_egress_read   = 1'b1;
    tick();
    local_egress_read   = 1'b0;
    check_all("pre_rst", 33'h0_0000000A, 3'd2, 1'b0, 3'd1, 1'b0, 1'b1);
    #2;
    local_arstn = 1'b0;
    #1;
    check_all("async_rst", '0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    local_arstn = 1'b1;
    router_egress_write = 1'b1;
    router_egress_data  = 33'h1_00000055;
    tick();
    router_egress_write = 1'b0;
    check("post_rst.level", 64'(local_egress_fifo_level), 64'd1);
    check("post_rst.pc", 64'(local_egress_packet_count), 64'd1);
    local_egress_read = 1'b1;
    tick();
    local_egress_read = 1'b0;
    check_all("post_rst_rd", 33'h1_00000055, '0, 1'b0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
